prefetch_queue: RTL



---
 rtl/prefetch_queue.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/prefetch_queue.sv
// -----------------------------------------------------------------------------
// prefetch_queue
//
// Instruction-byte prefetch buffer sitting between main memory and the
// instruction fetcher. After a redirect it streams sequential bytes from
// memory, starting at the redirect address, and holds up to DEPTH of them
// ahead of the fetcher. The fetcher drains bytes through a valid/ready
// handshake. A redirect (jump, branch, reset vector) flushes the buffer and
// restarts the stream.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   reset          synchronous, active-high reset (returns to IDLE)
//   redirect       load redirect_addr as the new stream start, flush queue
//   redirect_addr  new fetch address
//   mem_rd         read request to memory (combinational)
//   mem_addr       read address, meaningful while mem_rd=1
//   mem_gnt        memory accepts the request this cycle
//   mem_data       read data, valid the cycle after an accepted request
//   byte_out       head-of-queue byte (0 while empty)
//   byte_pc        address of byte_out (0 while empty)
//   byte_valid     queue non-empty
//   byte_ready     fetcher consumes the head byte when byte_valid=1
//   count          number of bytes currently held
// -----------------------------------------------------------------------------
module prefetch_queue #(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect,
    input  logic [ADDR_WIDTH-1:0]        redirect_addr,
    output logic                         mem_rd,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    input  logic                         mem_gnt,
    input  logic [DATA_WIDTH-1:0]        mem_data,
    output logic [DATA_WIDTH-1:0]        byte_out,
    output logic [ADDR_WIDTH-1:0]        byte_pc,
    output logic                         byte_valid,
    input  logic                         byte_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);      // pointer width, wraps naturally
    localparam int CW = $clog2(DEPTH+1);    // occupancy width, holds DEPTH

    typedef enum logic {
        IDLE = 1'b0,    // no stream address yet
        RUN  = 1'b1     // streaming from fetch_addr_q
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_addr_q, fetch_addr_d;
    logic [PW-1:0]           head_q, head_d;
    logic [PW-1:0]           tail_q, tail_d;
    logic [CW-1:0]           count_q, count_d;
    logic                    inflight_q, inflight_d;
    logic                    squash_q, squash_d;

    logic [DATA_WIDTH-1:0]   data_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   pc_q   [DEPTH];

    logic                    accept;
    logic                    push;
    logic                    pop;
    logic [CW:0]             occupancy;
    logic [ADDR_WIDTH-1:0]   ret_addr;

    // Credit check counts the byte already on its way back, so a request is
    // only issued when there is guaranteed room for its data. This keeps at
    // most one request outstanding and makes overflow impossible.
    assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign mem_rd    = (state_q == RUN) && !redirect
                       && (occupancy < (CW+1)'(DEPTH));
    assign mem_addr  = fetch_addr_q;
    assign accept    = mem_rd && mem_gnt;

    // The returning byte belongs to the address just before the current fetch
    // address: only one request can be outstanding and fetch_addr_q advanced
    // when it was accepted.
    assign ret_addr  = fetch_addr_q - ADDR_WIDTH'(1);

    // Redirect kills both a byte returning in its own cycle and the pop.
    assign push = (state_q == RUN) && inflight_q && !squash_q && !redirect;
    assign pop  = (count_q != '0) && byte_ready && !redirect;

    assign byte_valid = (count_q != '0);
    assign byte_out   = byte_valid ? data_q[head_q] : '0;
    assign byte_pc    = byte_valid ? pc_q[head_q]   : '0;
    assign count      = count_q;

    // NOTE: every signal driven here gets its hold value first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        inflight_d   = accept;
        // mem_rd is masked during redirect, so this only ever fires if that
        // masking is relaxed; it then drops the read accepted alongside it.
        squash_d     = redirect && accept;

        case (state_q)
            IDLE:    if (redirect) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = IDLE;
        endcase

        if (redirect) begin
            fetch_addr_d = redirect_addr;
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
        end else begin
            if (accept) fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
            if (push)   tail_d       = tail_q + PW'(1);
            if (pop)    head_d       = head_q + PW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            inflight_q   <= 1'b0;
            squash_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            squash_q     <= squash_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; an entry is only
    // visible once count covers it, and the outputs read 0 while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[tail_q] <= mem_data;
            pc_q[tail_q]   <= ret_addr;
        end
    end

endmodule
